addsub_serial: RTL
==================

Name: addsub_serial

Overview:
- Parametrised, multi-cycle, digit-serial adder/subtractor with a start/done handshake.
- Successor to the team's fixed 4-bit combinational add/sub. Generalised to WIDTH bits, processed DIGIT bits per clock.
- Produces registered result, carry/borrow, signed overflow and zero flags.
- Sits as an arithmetic unit behind a simple controller or datapath sequencer.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be ≥ 2.
- DIGIT, 2, bits processed per cycle. WIDTH % DIGIT must be 0; otherwise the build stops with an elaboration error.
- NDIG, WIDTH/DIGIT, derived (localparam): cycles per operation.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, request; sampled only when busy=0.
- select, input, 1, 0 = A+B, 1 = A−B (B inverted, carry-in = 1).
- A, input, WIDTH, operand A; captured on the accepted start.
- B, input, WIDTH, operand B; captured on the accepted start.
- sum_diff, output, WIDTH, result register.
- carry, output, 1, add: carry-out; subtract: borrow = NOT carry-out.
- overflow, output, 1, signed overflow = carry into MSB XOR carry out of MSB.
- zero, output, 1, result == 0.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle pulse: result and flags are valid.

Behaviour:
- Reset (async, any time, including mid-operation) forces:
  - state = IDLE;
  - sum_diff = 0, carry = 0, overflow = 0, zero = 0, busy = 0, done = 0;
  - digit counter = 0, internal operand shift registers = 0.
- States:
  - IDLE: start=1 → capture A, B XOR {WIDTH{select}}, carry-in = select, op = select, counter = 0; busy=1; go to RUN.
  - RUN: each cycle adds DIGIT low bits of A-reg + B-reg + running carry. The digit is shifted into the result register from the MSB side; A-reg and B-reg shift right by DIGIT.
    - When counter == NDIG−1: latch flags, busy=0, done=1, go to DONE.
    - Otherwise counter increments.
  - DONE: done=0 after one cycle. Same start acceptance as IDLE; with no start, go to IDLE.
- Latency: done is high during the cycle after the NDIG-th RUN edge. That is NDIG rising edges after the edge that accepts start. For DIGIT=WIDTH, done appears 1 cycle after accept.
- Back-to-back: start=1 while done=1 is accepted. No idle cycle is needed between operations.
- start while busy=1 is ignored; the operation in flight is unaffected.
- select, A and B are don't-care except on the accept edge.
- Outputs:
  - sum_diff holds its last completed value until the final edge of the next operation. Partial digits are never visible on sum_diff.
  - The result goes to a separate shift register and is copied to sum_diff on completion.
  - Flags update only on the completion edge.
- Arithmetic: modulo 2^WIDTH.
  - carry for subtract reports borrow (A < B unsigned).
  - overflow uses the two's-complement rule. The MSB carry-in is taken from the final digit.

Optional Feature:
- ADDSUB_SAT_EN defined: on overflow=1, sum_diff is clamped to the signed limit, still with overflow=1 reported.
  - Limit is 2^(WIDTH−1)−1 if operand A (as captured) is non-negative, else −2^(WIDTH−1).
  - zero and carry reflect the unclamped result.
- Not defined: wrap-around result only. No clamp logic is generated.

Decomposition:
- Package addsub_pkg:
  - state enum {IDLE, RUN, DONE};
  - OP_ADD = 1'b0, OP_SUB = 1'b1;
  - helper function for counter width clog2(NDIG) (minimum 1).
- Sub-module digit_adder:
  - DIGIT-bit ripple adder;
  - inputs a, b, cin; outputs s, cout, c_msb_in (carry into the top bit, for the overflow rule);
  - instantiated once in the RUN datapath.

Test Plan (WIDTH=8, DIGIT=2, NDIG=4):
- A=0x35, B=0x4A, select=0 → sum_diff=0x7F, carry=0, overflow=0, zero=0; done exactly 4 edges after the accept edge, busy high for those 4 cycles.
- A=0x10, B=0x20, select=1 → sum_diff=0xF0, carry(borrow)=1, overflow=0.
- A=0x7F, B=0x01, select=0 → overflow=1, carry=0; sum_diff=0x80, or 0x7F with ADDSUB_SAT_EN. Also A=0x80, B=0x01, select=1 → 0x7F, overflow=1, or 0x80 with ADDSUB_SAT_EN.
- A=0xFF, B=0x01, select=0 → sum_diff=0x00, carry=1, zero=1, overflow=0.
- Back-to-back accept in the DONE cycle, plus start pulsed at cycle 2 of RUN → the second start is ignored, the first result is unchanged, and the next op completes 4 edges after its accept.
- reset asserted asynchronously at RUN cycle 2 (between edges) → all outputs 0 immediately. After release, a new op (0x01+0x01) yields 0x02 correctly.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers for the digit-serial add/sub unit.
package addsub_pkg;

  // Operation encoding: subtract inverts B and injects a carry-in of 1
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Digit counter width; a single-digit operation still needs one bit
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: DIGIT-bit ripple-carry adder. Also exposes the carry into the
// top bit so the caller can apply the two's-complement overflow rule.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout     = w_c[DIGIT];
  assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock,
// start/done handshake. Define ADDSUB_SAT_EN to clamp overflowing results to
// the signed limit selected by the sign of the captured A operand.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             select,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum_diff,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  // Reject illegal configurations at elaboration time
  if (WIDTH < 2) begin : g_bad_width
    $error("addsub_serial: WIDTH must be >= 2");
  end
  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("addsub_serial: WIDTH must be a multiple of DIGIT");
  end

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_op;
  logic             r_cy;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_final;

  // Start is only honoured while no operation is in flight
  assign w_accept = (r_state != S_RUN) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(NDIG - 1));

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (r_a[DIGIT-1:0]),
    .b        (r_b[DIGIT-1:0]),
    .cin      (r_cy),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_cmsb)
  );

  // New digit enters from the MSB side so the LSB digit lands at bit 0 last
  assign w_res_nxt = (r_res >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));
  // On the final digit the adder's top bit is the word MSB
  assign w_ovf     = w_cmsb ^ w_cout;

`ifdef ADDSUB_SAT_EN
  logic r_a_sgn;

  // Sign of A as captured picks which signed limit to clamp to
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_a_sgn <= 1'b0;
    else if (w_accept) r_a_sgn <= A[WIDTH-1];
  end

  assign w_final = !w_ovf  ? w_res_nxt :
                   r_a_sgn ? {1'b1, {(WIDTH-1){1'b0}}} :
                             {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_final = w_res_nxt;
`endif

  // Controller: state, digit counter, busy and the one-cycle done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand and partial-result shift registers plus the running carry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cy  <= 1'b0;
      r_op  <= OP_ADD;
    end else if (w_accept) begin
      r_a  <= A;
      r_b  <= B ^ {WIDTH{select}};
      r_cy <= select;
      r_op <= select;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> DIGIT;
      r_b   <= r_b >> DIGIT;
      r_res <= w_res_nxt;
      r_cy  <= w_cout;
    end
  end

  // Visible result and flags change only on the completion edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_diff <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (w_last) begin
      sum_diff <= w_final;
      carry    <= (r_op == OP_SUB) ? ~w_cout : w_cout;
      overflow <= w_ovf;
      zero     <= (w_res_nxt == '0);
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule
